ext_mem_responder: RTL

Synthesizable responder for the CPU's external memory port. It is the memory-side end of the req/data/resp protocol that `riscv_top` drives. It accepts block read and write requests, holds data in an internal word-addressed RAM, and returns tagged read responses after a fixed, programmable latency. It replaces the behavioural memory model in FPGA and emulation builds, and it also serves as a reference responder for protocol-compliance benches.

---
 rtl/ext_mem_responder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ext_mem_responder.sv
// ext_mem_responder: memory-side end of the req/data/resp block protocol.
// Ports: clk/reset, req (valid/ready/rw/addr/tag), wdata (valid/ready/bits/mask), resp (valid/tag/data).
module ext_mem_responder #(
  parameter int ADDR_BITS  = 28,
  parameter int TAG_BITS   = 5,
  parameter int DATA_BITS  = 128,
  parameter int BEATS      = 4,
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_req_valid,
  output logic                   mem_req_ready,
  input  logic                   mem_req_rw,
  input  logic [ADDR_BITS-1:0]   mem_req_addr,
  input  logic [TAG_BITS-1:0]    mem_req_tag,
  input  logic                   mem_req_data_valid,
  output logic                   mem_req_data_ready,
  input  logic [DATA_BITS-1:0]   mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0] mem_req_data_mask,
  output logic                   mem_resp_valid,
  output logic [TAG_BITS-1:0]    mem_resp_tag,
  output logic [DATA_BITS-1:0]   mem_resp_data
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int NBYTES = DATA_BITS / 8;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WDATA = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [DEPTH_LOG2-1:0] BASE_MASK =
    ~DEPTH_LOG2'(BEATS - 1);

  logic [1:0]            state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic [DEPTH_LOG2-1:0] base_q, base_d;
  logic [TAG_BITS-1:0]   tag_q, tag_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [TAG_BITS-1:0]   resp_tag_q, resp_tag_d;
  logic [DATA_BITS-1:0]  resp_data_q;
  logic [DATA_BITS-1:0]  mem_q [DEPTH];

  logic                  last_beat;
  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  unused_addr;

  // Only the low DEPTH_LOG2 address bits select a beat; the rest wrap.
  assign unused_addr = ^mem_req_addr;

  // Ready lines decode straight from state, held low during reset.
  assign mem_req_ready      = reset & (state_q == S_IDLE);
  assign mem_req_data_ready = reset & (state_q == S_WDATA);

  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    base_d  = base_q;
    tag_d   = tag_q;
    case (state_q)
      S_IDLE: begin
        if (mem_req_valid) begin
          base_d = mem_req_addr[DEPTH_LOG2-1:0] & BASE_MASK;
          tag_d  = mem_req_tag;
          beat_d = '0;
          lat_d  = LAT_W'(LATENCY - 1);
          if (mem_req_rw)
            state_d = S_WDATA;
          else if (LATENCY == 1)
            state_d = S_RESP;
          else
            state_d = S_WAIT;
        end
      end
      S_WDATA: begin
        if (mem_req_data_valid) begin
          if (last_beat) begin
            beat_d  = '0;
            state_d = S_IDLE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      S_WAIT: begin
        lat_d = lat_q - LAT_W'(1);
        if (lat_d == '0)
          state_d = S_RESP;
      end
      S_RESP: begin
        if (last_beat) begin
          beat_d  = '0;
          state_d = S_IDLE;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Response registers are loaded one cycle ahead from the next state,
  // so the beat appears in the same cycle the FSM sits in RESP.
  always_comb begin
    resp_valid_d = (state_d == S_RESP);
    resp_tag_d   = resp_valid_d ? tag_d : '0;
    rd_idx       = base_d + DEPTH_LOG2'(beat_d);
  end

  assign wr_en  = reset & (state_q == S_WDATA) & mem_req_data_valid;
  assign wr_idx = base_q + DEPTH_LOG2'(beat_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      beat_q       <= '0;
      lat_q        <= '0;
      base_q       <= '0;
      tag_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_tag_q   <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      lat_q        <= lat_d;
      base_q       <= base_d;
      tag_q        <= tag_d;
      resp_valid_q <= resp_valid_d;
      resp_tag_q   <= resp_tag_d;
    end
  end

  // Synchronous read port; zero whenever no beat is being returned.
  always_ff @(posedge clk) begin
    if (!reset)
      resp_data_q <= '0;
    else if (resp_valid_d)
      resp_data_q <= mem_q[rd_idx];
    else
      resp_data_q <= '0;
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (mem_req_data_mask[b])
          mem_q[wr_idx][b*8 +: 8] <= mem_req_data_bits[b*8 +: 8];
      end
    end
  end

  assign mem_resp_valid = resp_valid_q;
  assign mem_resp_tag   = resp_tag_q;
  assign mem_resp_data  = resp_data_q;

endmodule
